// File: rtl/char_buf_scheduler.sv
// Round-robin write scheduler for the 16x16 character buffer.
// Each grant streams one 16-char line from the owning requester into the
// buffer row it owns (ROW_BASE + index). Writes only happen during vblnk_in.
// Ports:
//   pclk, rst_n      clock, async active-low reset
//   vblnk_in         write window (vertical blanking)
//   req[NREQ]        per-requester line-ready, held until done
//   char_in[NREQ*8]  per-requester char at column rd_col
//   gnt[NREQ]        one-hot current owner (registered)
//   rd_col[4]        column presented to the owner (registered)
//   done[NREQ]       one-cycle pulse when a line is complete
//   wr_en/wr_addr/wr_data  buffer write port (registered)
module char_buf_scheduler #(
    parameter int unsigned NREQ     = 13,
    parameter int unsigned ROW_BASE = 1
) (
    input  logic                pclk,
    input  logic                rst_n,
    input  logic                vblnk_in,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*8-1:0]   char_in,
    output logic [NREQ-1:0]     gnt,
    output logic [3:0]          rd_col,
    output logic [NREQ-1:0]     done,
    output logic                wr_en,
    output logic [7:0]          wr_addr,
    output logic [7:0]          wr_data
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [3:0]       rd_col_q, rd_col_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic             wr_en_q, wr_en_d;
    logic [7:0]       wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;

    logic             arb_found;
    logic [IW-1:0]    arb_pick;
    logic [IW-1:0]    arb_next;
    logic [7:0]       owner_char;
    logic             owner_req;
    logic [3:0]       owner_row;

    // Rotating search: first set req at or after the pointer, modulo NREQ.
    always_comb begin
        int unsigned idx;
        logic [IW-1:0] cand;
        arb_found = 1'b0;
        arb_pick  = '0;
        idx       = 0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            cand = IW'(idx);
            if (!arb_found && req[cand]) begin
                arb_found = 1'b1;
                arb_pick  = cand;
            end
        end
        arb_next = (arb_pick == IW'(NREQ - 1)) ? '0 : arb_pick + IW'(1);
    end

    // Character and request of the current owner.
    always_comb begin
        owner_char = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (owner_q == IW'(i)) begin
                owner_char = char_in[i*8 +: 8];
            end
        end
        owner_req = req[owner_q];
        owner_row = 4'(ROW_BASE) + 4'(owner_q);
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        gnt_d     = gnt_q;
        rd_col_d  = rd_col_q;
        done_d    = '0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    gnt_d    = NREQ'(1) << arb_pick;
                    owner_d  = arb_pick;
                    ptr_d    = arb_next;
                    rd_col_d = '0;
                    state_d  = S_XFER;
                end
            end
            S_XFER: begin
                // A dropped request abandons the line; it wins over a write.
                if (!owner_req) begin
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end else if (vblnk_in) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {owner_row, rd_col_q};
                    wr_data_d = owner_char;
                    rd_col_d  = rd_col_q + 4'd1;
                    if (rd_col_q == 4'hF) begin
                        done_d  = gnt_q;
                        gnt_d   = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            gnt_q     <= '0;
            rd_col_q  <= '0;
            done_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            gnt_q     <= gnt_d;
            rd_col_q  <= rd_col_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign gnt     = gnt_q;
    assign rd_col  = rd_col_q;
    assign done    = done_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_char_buf_scheduler.sv
// Bench for char_buf_scheduler: directed scenarios plus random traffic,
// checked every cycle against a line-level reference model.
module tb_char_buf_scheduler;

    localparam int NREQ     = 13;
    localparam int ROW_BASE = 1;

    logic                pclk;
    logic                rst_n;
    logic                vblnk_in;
    logic [NREQ-1:0]     req;
    logic [NREQ*8-1:0]   char_in;
    logic [NREQ-1:0]     gnt;
    logic [3:0]          rd_col;
    logic [NREQ-1:0]     done;
    logic                wr_en;
    logic [7:0]          wr_addr;
    logic [7:0]          wr_data;
    logic [7:0]          salt;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    char_buf_scheduler #(.NREQ(NREQ), .ROW_BASE(ROW_BASE)) dut (
        .pclk     (pclk),
        .rst_n    (rst_n),
        .vblnk_in (vblnk_in),
        .req      (req),
        .char_in  (char_in),
        .gnt      (gnt),
        .rd_col   (rd_col),
        .done     (done),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Requesters answer the presented column combinationally.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            char_in[i*8 +: 8] = 8'(i*16 + int'(rd_col)) ^ salt;
        end
    end

    function automatic logic [7:0] char_of(input int k, input int c);
        return 8'(k*16 + c) ^ salt;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: which line is in flight, which column is next,
    // and whose turn it is, in plain integers.
    int              m_owner = -1;
    int              m_col   = 0;
    int              m_ptr   = 0;
    bit              m_fin   = 1'b0;
    bit              m_vedge = 1'b0;
    logic [NREQ-1:0] e_gnt   = '0;
    logic [NREQ-1:0] e_done  = '0;
    logic            e_wen   = 1'b0;
    logic [7:0]      e_addr  = '0;
    logic [7:0]      e_data  = '0;
    int              e_rdcol = 0;

    task automatic model_step();
        bit found;
        e_wen   = 1'b0;
        e_done  = '0;
        m_vedge = vblnk_in;
        if (!rst_n) begin
            m_owner = -1; m_col = 0; m_ptr = 0; m_fin = 1'b0;
            e_gnt = '0; e_rdcol = 0;
        end else if (m_fin) begin
            m_fin = 1'b0;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int s = 0; s < NREQ; s++) begin
                int k;
                k = (m_ptr + s) % NREQ;
                if (!found && req[k]) begin
                    found   = 1'b1;
                    m_owner = k;
                    m_col   = 0;
                    m_ptr   = (k + 1) % NREQ;
                    e_gnt   = NREQ'(1) << k;
                    e_rdcol = 0;
                end
            end
        end else if (!req[m_owner]) begin
            m_owner = -1;
            e_gnt   = '0;
        end else if (vblnk_in) begin
            e_wen  = 1'b1;
            e_addr = 8'((ROW_BASE + m_owner) * 16 + m_col);
            e_data = char_of(m_owner, m_col);
            if (m_col == 15) begin
                e_done  = NREQ'(1) << m_owner;
                e_gnt   = '0;
                m_owner = -1;
                m_fin   = 1'b1;
            end else begin
                m_col++;
                e_rdcol = m_col;
            end
        end
    endtask

    // Logs for directed scenarios.
    logic [7:0] wl_addr[$];
    logic [7:0] wl_data[$];
    int         g_idx[$];
    int         g_cyc[$];
    int         d_idx[$];
    logic [NREQ-1:0] prev_gnt = '0;

    // Per-cycle compare against the model.
    always @(posedge pclk) begin
        cyc++;
        model_step();
        #1;
        check("wr_en", 32'(wr_en), 32'(e_wen));
        if (e_wen) begin
            check("wr_addr", 32'(wr_addr), 32'(e_addr));
            check("wr_data", 32'(wr_data), 32'(e_data));
        end
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("done", 32'(done), 32'(e_done));
        if (e_gnt != '0) check("rd_col", 32'(rd_col), 32'(e_rdcol));
        check("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
        if (wr_en) check("wr_en_in_vblnk", 32'(m_vedge), 32'd1);
        if (wr_en) begin
            wl_addr.push_back(wr_addr);
            wl_data.push_back(wr_data);
        end
        if (gnt != '0 && gnt != prev_gnt) begin
            for (int i = 0; i < NREQ; i++) if (gnt[i]) begin g_idx.push_back(i); g_cyc.push_back(cyc); end
        end
        for (int i = 0; i < NREQ; i++) if (done[i]) d_idx.push_back(i);
        prev_gnt = gnt;
    end

    task automatic tick();
        @(negedge pclk);
        req = req & ~done;
    endtask

    task automatic clear_logs();
        wl_addr.delete(); wl_data.delete();
        g_idx.delete(); g_cyc.delete(); d_idx.delete();
    endtask

    task automatic wait_req_clear(input int budget, input string name);
        int n;
        n = 0;
        while (req != '0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(req), 32'd0);
    endtask

    initial begin
        int n, row5, got4;
        logic [7:0] s3;
        rst_n = 1'b0; req = '0; vblnk_in = 1'b0; salt = '0;
        repeat (3) @(negedge pclk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rd_col", 32'(rd_col), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        rst_n = 1'b1;

        // Single line from requester 2.
        tick();
        clear_logs();
        salt = 8'h60; vblnk_in = 1'b1; req = NREQ'(1) << 2;
        wait_req_clear(40, "t2_timeout");
        repeat (3) tick();
        check("t2_nwrites", 32'(wl_addr.size()), 32'd16);
        for (int j = 0; j < 16 && j < wl_addr.size(); j++) begin
            check("t2_addr", 32'(wl_addr[j]), 32'(8'h30 + j));
            check("t2_data", 32'(wl_data[j]), 32'(8'h40 + j));
        end
        check("t2_ndone", 32'(d_idx.size()), 32'd1);
        if (d_idx.size() > 0) check("t2_done_idx", 32'(d_idx[0]), 32'd2);
        check("t2_gnt_idle", 32'(gnt), 32'd0);

        // Blanking pause after column 5.
        clear_logs();
        s3 = 8'($urandom); salt = s3; req = NREQ'(1) << 5;
        n = 0;
        while (wl_addr.size() < 6 && n < 30) begin tick(); n++; end
        vblnk_in = 1'b0;
        n = wl_addr.size();
        repeat (100) tick();
        check("t3_gap_writes", 32'(wl_addr.size()), 32'(n));
        vblnk_in = 1'b1;
        wait_req_clear(40, "t3_timeout");
        check("t3_nwrites", 32'(wl_addr.size()), 32'd16);
        if (wl_addr.size() > 6) check("t3_resume_addr", 32'(wl_addr[6]), 32'h66);
        for (int j = 0; j < 16 && j < wl_addr.size(); j++) begin
            check("t3_addr", 32'(wl_addr[j]), 32'(8'h60 + j));
            check("t3_data", 32'(wl_data[j]), 32'(8'(80 + j) ^ s3));
        end

        // Async reset in the middle of a line.
        clear_logs();
        req = NREQ'(1) << 9;
        n = 0;
        while (wl_addr.size() < 3 && n < 30) begin tick(); n++; end
        #2 rst_n = 1'b0;
        #1;
        check("t1_gnt", 32'(gnt), 32'd0);
        check("t1_rd_col", 32'(rd_col), 32'd0);
        check("t1_done", 32'(done), 32'd0);
        check("t1_wr_en", 32'(wr_en), 32'd0);
        check("t1_wr_addr", 32'(wr_addr), 32'd0);
        check("t1_wr_data", 32'(wr_data), 32'd0);
        req = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("t1_idle_after", 32'(gnt), 32'd0);

        // All requesters at once: round-robin from pointer 0.
        clear_logs();
        req = '1;
        wait_req_clear(13*18 + 50, "t4_timeout");
        check("t4_ngrants", 32'(g_idx.size()), 32'd13);
        for (int j = 0; j < 13 && j < g_idx.size(); j++) check("t4_order", 32'(g_idx[j]), 32'(j));
        if (g_cyc.size() == 13) check("t4_span", 32'(g_cyc[12] - g_cyc[0]), 32'd216);

        // Pointer wrap: serve 11 so the pointer sits at 12, then {12, 0}.
        req = NREQ'(1) << 11;
        wait_req_clear(40, "t5_pre_timeout");
        repeat (2) tick();
        clear_logs();
        req = (NREQ'(1) << 12) | NREQ'(1);
        wait_req_clear(60, "t5_timeout");
        check("t5_ngrants", 32'(g_idx.size()), 32'd2);
        if (g_idx.size() >= 2) begin
            check("t5_first", 32'(g_idx[0]), 32'd12);
            check("t5_second", 32'(g_idx[1]), 32'd0);
        end

        // Abort: requester 4 drops at column 7; requester 7 is next.
        repeat (2) tick();
        clear_logs();
        req = (NREQ'(1) << 4) | (NREQ'(1) << 7);
        n = 0;
        while (!(gnt[4] && rd_col == 4'd7) && n < 30) begin tick(); n++; end
        check("t6_reached_col7", 32'(gnt[4] && rd_col == 4'd7), 32'd1);
        req[4] = 1'b0;
        tick();
        check("t6_wr_en_off", 32'(wr_en), 32'd0);
        check("t6_gnt_off", 32'(gnt), 32'd0);
        wait_req_clear(60, "t6_timeout");
        row5 = 0;
        foreach (wl_addr[j]) if (wl_addr[j][7:4] == 4'd5) row5++;
        check("t6_row5_writes", 32'(row5), 32'd7);
        got4 = 0;
        foreach (d_idx[j]) if (d_idx[j] == 4) got4++;
        check("t6_no_done4", 32'(got4), 32'd0);
        check("t6_ngrants", 32'(g_idx.size()), 32'd2);
        if (g_idx.size() >= 2) check("t6_next_owner", 32'(g_idx[1]), 32'd7);

        // Random traffic; the per-cycle compare does the checking.
        repeat (3000) begin
            tick();
            if ($urandom_range(0, 19) == 0) vblnk_in = ~vblnk_in;
            if ($urandom_range(0, 7) == 0) salt = 8'($urandom);
            for (int i = 0; i < NREQ; i++) if (!req[i] && $urandom_range(0, 39) == 0) req[i] = 1'b1;
            if (gnt != '0 && $urandom_range(0, 149) == 0) req = req & ~gnt;
        end
        vblnk_in = 1'b1;
        wait_req_clear(13*18 + 100, "drain_timeout");
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
